// File: rtl/pcpi_approx_mul_seq.sv
// pcpi_approx_mul_seq: PCPI coprocessor on the custom-0 opcode. It shares one
// SCDM8_51 approximate 8x8 multiplier across the four byte lanes, one lane per
// cycle, and holds the CPU with pcpi_wait while it iterates.
// Optional feature: define APPROX_MUL_DOT_EN to decode funct3=011 as DOT
// (the four lane products summed, zero-extended).

// SCDM8_51: unsigned 8x8 approximate multiplier. Every partial product drops
// its four least-significant bits before accumulation, so the result never
// exceeds the exact product.
module SCDM8_51 (
  input  logic [7:0]  c,
  input  logic [7:0]  d,
  output logic [15:0] resultX
);
  // truncated shift-and-add accumulation
  always_comb begin
    resultX = '0;
    for (int i = 0; i < 8; i++)
      if (d[i]) resultX = resultX + (({8'b0, c} << i) & 16'hFFF0);
  end
endmodule

module pcpi_approx_mul_seq #(
  parameter logic [6:0] FUNCT7 = 7'b000_0001
) (
`ifdef USE_POWER_PINS
  inout  wire         vdd,
  inout  wire         vss,
`endif
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready
);
  typedef enum logic [1:0] {IDLE, MUL, RESP, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       rs1_q, rs2_q;
  logic [2:0]        f3_q;
  logic [3:0][15:0]  p_q, p_d;
  logic [31:0]       rd_q, rd_d;
  logic              wr_q, wait_q, ready_q;
  logic              wait_d, ready_d;
  logic              f3_ok, hit;
  logic [1:0]        last_lane;
  logic [15:0]       prod;

  // Register fields that take no part in decode.
  logic unused_insn;
`ifdef USE_POWER_PINS
  assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7], vdd, vss};
`else
  assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};
`endif

  // decode: supported funct3 values of this unit
  always_comb begin
    f3_ok = 1'b0;
    case (pcpi_insn[14:12])
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
`ifdef APPROX_MUL_DOT_EN
      3'b011:                 f3_ok = 1'b1;
`endif
      default:                f3_ok = 1'b0;
    endcase
  end

  assign hit = pcpi_valid && (pcpi_insn[6:0] == 7'b000_1011) &&
               (pcpi_insn[31:25] == FUNCT7) && f3_ok;

  // Dual multiply only needs the two low lanes.
  assign last_lane = (f3_q == 3'b000) ? 2'd1 : 2'd3;

  // The single shared multiplier, fed from the latched operand byte of the current lane.
  SCDM8_51 u_mul (
    .c       (rs1_q[{lane_q, 3'b000} +: 8]),
    .d       (rs2_q[{lane_q, 3'b000} +: 8]),
    .resultX (prod)
  );

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      lane_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
    end
  end

  // next-state: walk the lanes, then one RESP and one FLUSH cycle
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    case (state_q)
      IDLE:  if (hit) begin
               state_d = MUL;
               lane_d  = 2'd0;
             end
      MUL:   if (lane_q == last_lane) state_d = RESP;
             else                     lane_d  = lane_q + 2'd1;
      RESP:  state_d = FLUSH;
      FLUSH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the next state. The
  // result is formed from the product set including the lane captured on the
  // same edge that enters RESP.
  always_comb begin
`ifdef APPROX_MUL_DOT_EN
    logic [17:0] dot_sum;
`endif
    p_d = p_q;
    if (state_q == MUL) p_d[lane_q] = prod;
`ifdef APPROX_MUL_DOT_EN
    dot_sum = {2'b0, p_d[0]} + {2'b0, p_d[1]} + {2'b0, p_d[2]} + {2'b0, p_d[3]};
`endif
    wait_d  = (state_d == MUL);
    ready_d = (state_d == RESP);
    rd_d    = rd_q;
    if (state_q == MUL && state_d == RESP) begin
      case (f3_q)
        3'b000:  rd_d = {p_d[1], p_d[0]};
        3'b001:  rd_d = {p_d[3][7:0], p_d[2][7:0], p_d[1][7:0], p_d[0][7:0]};
        3'b010:  rd_d = {p_d[3][15:8], p_d[2][15:8], p_d[1][15:8], p_d[0][15:8]};
`ifdef APPROX_MUL_DOT_EN
        3'b011:  rd_d = {14'd0, dot_sum};
`endif
        default: rd_d = rd_q;
      endcase
    end
  end

  // datapath and output registers; operands latched once at acceptance
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rs1_q   <= '0;
      rs2_q   <= '0;
      f3_q    <= '0;
      p_q     <= '0;
      rd_q    <= '0;
      wr_q    <= 1'b0;
      wait_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      if (state_q == IDLE && hit) begin
        rs1_q <= pcpi_rs1;
        rs2_q <= pcpi_rs2;
        f3_q  <= pcpi_insn[14:12];
      end
      p_q     <= p_d;
      rd_q    <= rd_d;
      wr_q    <= ready_d;
      wait_q  <= wait_d;
      ready_q <= ready_d;
    end
  end

  assign pcpi_wr    = wr_q;
  assign pcpi_rd    = rd_q;
  assign pcpi_wait  = wait_q;
  assign pcpi_ready = ready_q;
endmodule

// File: tb/tb_pcpi_approx_mul_seq.sv
// Scoreboard bench for pcpi_approx_mul_seq: the driver pushes the expected
// result, ready cycle and wait length of each accepted instruction; a
// negedge monitor pops and compares whenever pcpi_ready is seen.
module tb_pcpi_approx_mul_seq;
  localparam logic [6:0] F7 = 7'b000_0001;

  logic        clk = 1'b0;
  logic        resetn;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0] pcpi_rd;

  pcpi_approx_mul_seq #(.FUNCT7(F7)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pcpi_valid (pcpi_valid),
    .pcpi_insn  (pcpi_insn),
    .pcpi_rs1   (pcpi_rs1),
    .pcpi_rs2   (pcpi_rs2),
    .pcpi_wr    (pcpi_wr),
    .pcpi_rd    (pcpi_rd),
    .pcpi_wait  (pcpi_wait),
    .pcpi_ready (pcpi_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    int          rcyc;
    int          n;
  } exp_t;

  exp_t        sbq[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          waitcnt = 0;
  logic [31:0] last_rd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Approximate 8x8 product: shift-and-add where each partial product loses
  // its value modulo 16.
  function automatic int unsigned amul(input int unsigned a, input int unsigned b);
    int unsigned s = 0;
    int unsigned pp;
    for (int i = 0; i < 8; i++)
      if (((b >> i) & 1) == 1) begin
        pp = a * (1 << i);
        s += pp - (pp % 16);
      end
    return s;
  endfunction

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int unsigned p[4];
    int unsigned r;
    for (int k = 0; k < 4; k++)
      p[k] = amul((a >> (8 * k)) & 255, (b >> (8 * k)) & 255);
    case (f3)
      3'b000:  r = p[1] * 65536 + p[0];
      3'b001:  r = (p[3] % 256) * 16777216 + (p[2] % 256) * 65536 + (p[1] % 256) * 256 + (p[0] % 256);
      3'b010:  r = (p[3] / 256) * 16777216 + (p[2] / 256) * 65536 + (p[1] / 256) * 256 + (p[0] / 256);
      default: r = p[0] + p[1] + p[2] + p[3];
    endcase
    return r;
  endfunction

  // monitor: every response must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (!resetn) waitcnt = 0;
    else begin
      if (pcpi_wait) waitcnt++;
      if (pcpi_ready) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ready: got ready=1 rd=%h expected no response (cycle %0d)", pcpi_rd, cyc);
        end else begin
          e = sbq.pop_front();
          chk("rd", pcpi_rd, e.rd);
          chk("wr_with_ready", {31'b0, pcpi_wr}, 32'd1);
          chk("wait_in_resp", {31'b0, pcpi_wait}, 32'd0);
          chk("ready_cycle", cyc, e.rcyc);
          chk("wait_cycles", waitcnt, e.n);
        end
        waitcnt = 0;
      end
    end
  end

  // Offer an instruction in the current cycle (cycle 0) and keep valid high
  // through FLUSH. Returns in the first cycle after FLUSH with valid still
  // high, so the caller either starts the next one or drops valid.
  // mode 1: operands zeroed in cycle 2; mode 2: operands scrambled every cycle.
  task automatic start(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input int mode);
    exp_t e;
    int   n;
    n          = (f3 == 3'b000) ? 2 : 4;
    pcpi_valid = 1'b1;
    pcpi_insn  = {F7, 5'd2, 5'd1, f3, 5'd3, 7'b000_1011};
    pcpi_rs1   = a;
    pcpi_rs2   = b;
    e.rd       = model(f3, a, b);
    e.rcyc     = cyc + n + 1;
    e.n        = n;
    sbq.push_back(e);
    last_rd    = e.rd;
    for (int j = 1; j <= n + 3; j++) begin
      @(posedge clk); #1;
      if (mode == 1 && j == 2) begin pcpi_rs1 = '0; pcpi_rs2 = '0; end
      if (mode == 2) begin pcpi_rs1 = $urandom; pcpi_rs2 = $urandom; end
    end
  endtask

  // Offer an instruction this unit must ignore; hold it for 20 cycles.
  task automatic miss(input logic [2:0] f3, input logic [6:0] f7);
    pcpi_valid = 1'b1;
    pcpi_insn  = {f7, 5'd2, 5'd1, f3, 5'd3, 7'b000_1011};
    pcpi_rs1   = $urandom;
    pcpi_rs2   = $urandom;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
      chk("miss_wait", {31'b0, pcpi_wait}, 32'd0);
      chk("miss_rd_held", pcpi_rd, last_rd);
    end
    pcpi_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f3;
    resetn     = 1'b0;
    pcpi_valid = 1'b0;
    pcpi_insn  = '0;
    pcpi_rs1   = '0;
    pcpi_rs2   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wait", {31'b0, pcpi_wait}, 32'd0);
    chk("reset_ready", {31'b0, pcpi_ready}, 32'd0);
    chk("reset_wr", {31'b0, pcpi_wr}, 32'd0);
    chk("reset_rd", pcpi_rd, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // directed: quad high, dual, operand capture, back-to-back
    start(3'b010, 32'h11223344, 32'h55667788, 0);
    start(3'b000, 32'hFFFF_C8C8, 32'hFFFF_0F0F, 0);
    start(3'b001, 32'hA5C3_7E19, 32'h3CF0_81FF, 1);
    start(3'b001, 32'h0102_0304, 32'hFEDC_BA98, 0);
    pcpi_valid = 1'b0;

    // decode misses
    miss(3'b100, F7);
    miss(3'b000, 7'b000_0000);
`ifdef APPROX_MUL_DOT_EN
    start(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    pcpi_valid = 1'b0;
`else
    miss(3'b011, F7);
`endif

    // reset in cycle 2 of a quad multiply
    @(posedge clk); #1;
    pcpi_valid = 1'b1;
    pcpi_insn  = {F7, 5'd2, 5'd1, 3'b001, 5'd3, 7'b000_1011};
    pcpi_rs1   = 32'h1234_5678;
    pcpi_rs2   = 32'h9ABC_DEF0;
    repeat (2) begin @(posedge clk); #1; end
    chk("mul_wait_before_reset", {31'b0, pcpi_wait}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("rst_mid_wait", {31'b0, pcpi_wait}, 32'd0);
    chk("rst_mid_ready", {31'b0, pcpi_ready}, 32'd0);
    chk("rst_mid_wr", {31'b0, pcpi_wr}, 32'd0);
    chk("rst_mid_rd", pcpi_rd, 32'd0);
    pcpi_valid = 1'b0;
    last_rd    = '0;
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    start(3'b001, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    pcpi_valid = 1'b0;

    // randomized instruction stream with scrambled operands after acceptance
    for (int t = 0; t < 30; t++) begin
`ifdef APPROX_MUL_DOT_EN
      f3 = 3'($urandom_range(0, 3));
`else
      f3 = 3'($urandom_range(0, 2));
`endif
      start(f3, $urandom, $urandom, 2);
      if ($urandom_range(0, 1) == 1) begin
        pcpi_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
    end
    pcpi_valid = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    chk("responses_outstanding", sbq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pcpi_approx_mul_seq.md
# pcpi_approx_mul_seq

Sequenced PCPI coprocessor that time-shares a single `SCDM8_51` approximate 8×8 multiplier across the four byte lanes of `pcpi_rs1`/`pcpi_rs2`, one lane per cycle. It trades the four-instance, single-cycle multiplier for about one quarter of the multiplier area at 2–4 cycles of latency. It holds the CPU with `pcpi_wait` while it iterates. It attaches to the PicoRV32 PCPI bus in the caravel user area in place of the parallel approximate-multiply coprocessor, and uses the same custom-0 encoding.

## Interface
Parameters:
- `FUNCT7`, default 7'b000_0001: `pcpi_insn[31:25]` value that selects this unit.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `resetn`  in  1  reset is asynchronous and active-low.
- `vdd`, `vss`  inout  1  power pins, present only under `USE_POWER_PINS`.
- `pcpi_valid`  in  1  CPU instruction offer.
- `pcpi_insn`  in  32  instruction word.
- `pcpi_rs1`, `pcpi_rs2`  in  32  source operands; byte lane k is bits [8k+7:8k].
- `pcpi_wr`  out  1  write-back strobe, registered.
- `pcpi_rd`  out  32  result, registered.
- `pcpi_wait`  out  1  busy indication, registered.
- `pcpi_ready`  out  1  completion strobe, registered.

## Operation
Decode (`hit`):
- `hit` = `pcpi_valid` & `insn[6:0]`==7'b000_1011 & `insn[31:25]`==`FUNCT7` & funct3 supported.
- Supported funct3 values: 000 (MUL_D), 001 (MUL_QL), 010 (MUL_QH), and 011 (DOT) only when `APPROX_MUL_DOT_EN` is defined.
- Unsupported funct3 is ignored: no wait, no ready. The CPU's illegal-instruction timeout handles it.

Datapath:
- One `SCDM8_51` instance. Its `c`/`d` inputs are muxed from the latched rs1/rs2 byte selected by lane counter `lane` (2 bits).
- Product registers `p0`..`p3`, 16 bits each. `p[lane]` captures `resultX` at the end of each MUL cycle.

FSM states: IDLE, MUL, RESP, FLUSH.
- **IDLE:** on `hit`, latch rs1, rs2 and funct3; `lane`←0; go to MUL.
- **MUL:** capture `p[lane]`.
  - Last lane is 1 for MUL_D and 3 otherwise.
  - If `lane` equals the last lane, go to RESP; else `lane`←`lane`+1.
- **RESP:** one cycle, then FLUSH. Result formation on `pcpi_rd`:
  - MUL_D: {p1, p0}.
  - MUL_QL: {p3[7:0], p2[7:0], p1[7:0], p0[7:0]}.
  - MUL_QH: {p3[15:8], p2[15:8], p1[15:8], p0[15:8]}.
  - DOT: zero-extended unsigned p0+p1+p2+p3, computed as an 18-bit sum (max 4×65025 fits in 18 bits).
- **FLUSH:** one cycle with `pcpi_valid` ignored, because the CPU drops `pcpi_valid` one cycle after `pcpi_ready`. Then go to IDLE.

General rules:
- Latched operands are used throughout. Changes on `pcpi_rs*` after acceptance have no effect.
- If `pcpi_valid` falls during MUL, the sequence still completes and RESP still fires; the CPU discards the strobe.

## Timing
Cycle numbering: cycle 0 is the IDLE cycle in which `hit` is sampled.

Outputs per state:
- `pcpi_wait` = 1 exactly while in MUL (cycles 1..N).
- `pcpi_ready` = `pcpi_wr` = 1 exactly while in RESP, for one cycle; `pcpi_wait` = 0 in that cycle.
- `pcpi_rd` is valid in the RESP cycle and holds that value until the next RESP.

Latency:
- MUL_D: N=2, so ready in cycle 3.
- MUL_QL, MUL_QH, DOT: N=4, so ready in cycle 5.

Throughput: at most one instruction per N+3 cycles. A `hit` is accepted at the earliest in the cycle after FLUSH.

Reset (`resetn` low), asynchronous and effective mid-operation:
- State←IDLE, `lane`←0.
- `p0`..`p3`, latched operands, `pcpi_rd` ← 0.
- `pcpi_wr`, `pcpi_wait`, `pcpi_ready` ← 0.
- No partial RESP is produced after reset is released.
- Deassertion is taken on a clock edge. `hit` in the first cycle after release is accepted normally.

## Configuration
`APPROX_MUL_DOT_EN`:
- **Defined:** funct3=011 decodes as DOT, with a 4-lane sequence and result equal to the summed products zero-extended to 32 bits.
- **Undefined:** funct3=011 is unsupported and ignored. The adder and its result-mux leg are absent.

## Test plan
Expected products come from a standalone `SCDM8_51` model driven with the same bytes.
- **Quad high-half:** MUL_QH, rs1=0x11223344, rs2=0x55667788 → wait high cycles 1–4; ready+wr in cycle 5 only; rd = {model(11,55)[15:8], model(22,66)[15:8], model(33,77)[15:8], model(44,88)[15:8]}.
- **Dual:** MUL_D, rs1=0xFFFF_C8C8, rs2=0xFFFF_0F0F → ready in cycle 3; rd = {model(C8,0F), model(C8,0F)}; upper operand bytes have no effect.
- **Decode misses:** funct3=100, and separately funct7=0000000, with valid held 20 cycles → wait, ready and wr stay 0 and rd is unchanged. funct3=011 behaves the same when the macro is undefined.
- **Operand capture and back-to-back:** MUL_QL with rs1/rs2 changed to 0 during cycle 2 → result still uses the cycle-0 operands. Valid held through the FLUSH cycle → no second RESP. A new MUL_QL offered right after FLUSH completes in 5 cycles.
- **Mid-operation reset:** resetn pulsed low in cycle 2 of MUL_QL → all outputs 0 immediately, no ready afterwards, and the next instruction completes correctly.
- **DOT (macro defined):** rs1=rs2=0xFFFFFFFF → rd = 4×model(FF,FF), ready in cycle 5.
